// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesting ports (CPU, loader/debug),
// the arbiter, and the four byte-lane SRAMs.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 15
);
  // CPU port
  logic              c_req;
  logic              c_we;
  logic [3:0]        c_be;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [31:0]       c_rdata;
  logic              c_ack;

  // Loader/debug port
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ack;

  // Current owner, one-hot: bit0 = CPU, bit1 = debug
  logic [1:0]        gnt;

  // Shared SRAM side
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic [3:0]        sram_ce_n;
  logic              sram_we_n;
  logic              sram_oe_n;

  // Arbiter view
  modport slave (
    input  c_req, c_we, c_be, c_addr, c_wdata,
    output c_rdata, c_ack,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_rdata, d_ack,
    output gnt,
    output sram_addr, sram_wdata, sram_ce_n, sram_we_n, sram_oe_n,
    input  sram_rdata
  );

  // Requester / SRAM-model view
  modport master (
    output c_req, c_we, c_be, c_addr, c_wdata,
    input  c_rdata, c_ack,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_rdata, d_ack,
    input  gnt,
    input  sram_addr, sram_wdata, sram_ce_n, sram_we_n, sram_oe_n,
    output sram_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a byte-lane data SRAM.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transfer; pick a winner and latch its request
// ACCESS | SRAM strobes active for WAIT_CYC cycles (down-counter)
// DONE   | one cycle, owner's ack high, strobes released
//
// All SRAM strobes, gnt, acks and rdata are registered so the SRAM pins
// never glitch on request changes and reset deasserts them immediately.
module dmem_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int WAIT_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Counter is loaded with WAIT_CYC-1 and ACCESS ends at terminal count 0.
  localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYC - 1);

  state_t            state;
  logic [2:0]        cnt;
  logic              owner_dbg;
  logic              last_dbg;
  logic              lat_we;
  logic [1:0]        gnt_q;
  logic              c_ack_q;
  logic              d_ack_q;
  logic [31:0]       c_rdata_q;
  logic [31:0]       d_rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        ce_n_q;
  logic              we_n_q;
  logic              oe_n_q;

  logic              pick_dbg;
  logic              sel_we;
  logic [3:0]        sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  // Round-robin winner: on contention the port not served last wins,
  // a lone requester always wins.
  always_comb begin
    pick_dbg = bus.d_req & (~bus.c_req | ~last_dbg);
    if (pick_dbg) begin
      sel_we    = bus.d_we;
      sel_be    = bus.d_be;
      sel_addr  = bus.d_addr;
      sel_wdata = bus.d_wdata;
    end else begin
      sel_we    = bus.c_we;
      sel_be    = bus.c_be;
      sel_addr  = bus.c_addr;
      sel_wdata = bus.c_wdata;
    end
  end

  // Transfer sequencer with registered SRAM strobes, grant, acks and rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      owner_dbg <= 1'b0;
      last_dbg  <= 1'b1;
      lat_we    <= 1'b0;
      gnt_q     <= 2'b00;
      c_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      c_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      ce_n_q    <= 4'hF;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
    end else begin
      c_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.c_req || bus.d_req) begin
            owner_dbg <= pick_dbg;
            last_dbg  <= pick_dbg;
            gnt_q     <= pick_dbg ? 2'b10 : 2'b01;
            lat_we    <= sel_we;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            ce_n_q    <= ~sel_be;
            we_n_q    <= ~sel_we;
            oe_n_q    <= sel_we;
            cnt       <= CNT_LOAD;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt == 3'd0) begin
            ce_n_q <= 4'hF;
            we_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            // Read data is sampled on the last ACCESS cycle while OE is low.
            if (!lat_we) begin
              if (owner_dbg) d_rdata_q <= bus.sram_rdata;
              else           c_rdata_q <= bus.sram_rdata;
            end
            if (owner_dbg) d_ack_q <= 1'b1;
            else           c_ack_q <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_DONE: begin
          gnt_q <= 2'b00;
          state <= S_IDLE;
        end
        default: begin
          gnt_q  <= 2'b00;
          ce_n_q <= 4'hF;
          we_n_q <= 1'b1;
          oe_n_q <= 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.c_ack      = c_ack_q;
  assign bus.d_ack      = d_ack_q;
  assign bus.c_rdata    = c_rdata_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_ce_n  = ce_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_oe_n  = oe_n_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, SRAM word-address width, matching the byte address bits [16:2].
REQ-002 Parameter WAIT_CYC, default 1, number of ACCESS cycles per SRAM transfer; legal range 1..7.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 c_req  in  1  CPU port request; held high until c_ack.
REQ-006 c_we  in  1  CPU port write (1) / read (0).
REQ-007 c_be  in  4  CPU port byte enables, active-high, bit i = byte lane i.
REQ-008 c_addr  in  ADDR_W  CPU port word address.
REQ-009 c_wdata  in  32  CPU port write data.
REQ-010 c_rdata  out  32  CPU port read data, registered.
REQ-011 c_ack  out  1  CPU port completion, one-cycle pulse.
REQ-012 d_req, d_we, d_be, d_addr, d_wdata, d_rdata, d_ack  same directions, widths and meanings as REQ-005..011, for the loader/debug port.
REQ-013 gnt  out  2  one-hot current owner: bit0 = CPU, bit1 = debug; 00 when idle.
REQ-014 sram_addr  out  ADDR_W  shared address to all four byte-lane SRAMs.
REQ-015 sram_wdata  out  32  write data to the byte lanes.
REQ-016 sram_rdata  in  32  read data from the byte lanes.
REQ-017 sram_ce_n  out  4  per-lane chip enable, active-low.
REQ-018 sram_we_n  out  1  write strobe, active-low.
REQ-019 sram_oe_n  out  1  output enable, active-low.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-021 IDLE: if any request is high, the FSM SHALL latch the winner's we/be/addr/wdata, set gnt, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-022 Arbitration SHALL be round-robin: on simultaneous c_req and d_req, the port not served last SHALL win; a single requester SHALL always win.
REQ-023 ACCESS SHALL last exactly WAIT_CYC cycles, counted by a 3-bit counter; the FSM SHALL then go to DONE.
REQ-024 DONE SHALL last one cycle, during which the owner's ack is high; the next state SHALL be IDLE and gnt SHALL clear.
REQ-025 Latency: request first high in IDLE at cycle N -> ack high at cycle N+WAIT_CYC+1; peak throughput is one transfer per WAIT_CYC+2 cycles.
REQ-026 sram_addr and sram_wdata SHALL be driven from the latched values and stay stable through ACCESS and DONE.
REQ-027 sram_ce_n[i] SHALL be low only in ACCESS with latched be[i]=1; otherwise it is high.
REQ-028 Write: sram_we_n SHALL be low for all ACCESS cycles and high in DONE; sram_oe_n SHALL stay high.
REQ-029 Read: sram_oe_n SHALL be low in ACCESS; sram_rdata SHALL be captured on the last ACCESS cycle into the owner's rdata.
REQ-030 Each port's rdata SHALL hold its value until that port's next read completes; writes SHALL leave rdata unchanged.
REQ-031 A request with be=0000 SHALL complete with normal timing and ack, with all sram_ce_n high.
REQ-032 A request still high in the IDLE cycle after its ack SHALL be treated as a new transfer.
REQ-033 Request changes while a transfer is in ACCESS/DONE SHALL NOT affect that transfer.

Reset
REQ-034 While rst is high, asynchronously: FSM=IDLE, counter=0, gnt=00, c_ack=d_ack=0, sram_ce_n=1111, sram_we_n=1, sram_oe_n=1, c_rdata=d_rdata=0, sram_addr=0, sram_wdata=0.
REQ-035 The round-robin pointer SHALL reset to "debug served last", so the CPU wins the first contention.
REQ-036 A reset during ACCESS SHALL abort the transfer with no ack, and sram_we_n SHALL rise immediately.

Verification
REQ-037 WAIT_CYC=1, CPU write addr 0x0010, be=1111, data 0xDEADBEEF, then read -> ack at cycle N+2 each time; c_rdata=0xDEADBEEF.
REQ-038 CPU byte write be=0100 data 0x00AB0000 -> only sram_ce_n[2] low; subsequent word read returns the old bytes with lane 2 = 0xAB.
REQ-039 c_req and d_req both high continuously after reset -> grants alternate CPU, debug, CPU, debug; each ack pulse is exactly one cycle.
REQ-040 WAIT_CYC=3, debug read -> sram_oe_n low exactly 3 cycles, d_ack at cycle N+4, c_rdata unchanged.
REQ-041 rst asserted in the 2nd ACCESS cycle of a write -> sram_we_n/ce_n high in the same cycle, no ack; FSM returns to IDLE after reset is released.
REQ-042 be=0000 request -> ack at N+WAIT_CYC+1, no sram_ce_n low at any time.
